// File: rtl/ff_chk_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ff_chk_pkg
// Description : Shared state type and default constants for ff_resp_checker.
// Revision    : 1.0 - initial release
// ============================================================================
package ff_chk_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } chk_state_t;

  localparam int c_DEF_LATENCY    = 1;
  localparam int c_DEF_NUM_CHECKS = 8;
  localparam int c_DEF_CNT_W      = 8;

  // Sliced to CNT_W at the point of use; supports counters up to 32 bits.
  localparam logic [31:0] c_FIRST_ERR_NONE = '1;

endpackage
`default_nettype wire

// File: rtl/ff_chk_delay_line.sv
`default_nettype none
// ============================================================================
// Module      : ff_chk_delay_line
// Description : LATENCY-deep {tag,data} shift register, synchronous clear,
//               asynchronous active-low reset. Entry 0 is the head.
// Revision    : 1.0 - initial release
// ============================================================================
module ff_chk_delay_line #(
  parameter int LATENCY = 1
) (
  input  logic clk,
  input  logic rstn,
  input  logic i_clr,
  input  logic i_en,
  input  logic i_tag,
  input  logic i_data,
  output logic o_tail_tag,
  output logic o_tail_data,
  output logic o_tail_tag_nxt
);

  logic [LATENCY-1:0] r_tag;
  logic [LATENCY-1:0] r_data;
  logic               w_tag_into_tail;

  generate
    if (LATENCY == 1) begin : g_single
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          r_tag  <= '0;
          r_data <= '0;
        end else if (i_clr) begin
          r_tag  <= '0;
          r_data <= '0;
        end else if (i_en) begin
          r_tag  <= i_tag;
          r_data <= i_data;
        end
      end
      assign w_tag_into_tail = i_tag;
    end else begin : g_multi
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          r_tag  <= '0;
          r_data <= '0;
        end else if (i_clr) begin
          r_tag  <= '0;
          r_data <= '0;
        end else if (i_en) begin
          r_tag  <= {r_tag[LATENCY-2:0], i_tag};
          r_data <= {r_data[LATENCY-2:0], i_data};
        end
      end
      assign w_tag_into_tail = r_tag[LATENCY-2];
    end
  endgenerate

  assign o_tail_tag     = r_tag[LATENCY-1];
  assign o_tail_data    = r_data[LATENCY-1];
  // Tag that lands in the tail on the coming edge, only if the line advances.
  assign o_tail_tag_nxt = i_en && !i_clr && w_tag_into_tail;

endmodule
`default_nettype wire

// File: rtl/ff_resp_checker.sv
`default_nettype none
// ============================================================================
// Module      : ff_resp_checker
// Description : Re-times the stimulus bit by LATENCY cycles, compares it with
//               the DUT output, counts checks/mismatches and gives a verdict.
//               Optional macro: FF_RESP_CHECKER_FIRST_ERR_EN (first error index).
// Revision    : 1.0 - initial release
// ============================================================================
module ff_resp_checker
  import ff_chk_pkg::*;
#(
  parameter int LATENCY    = c_DEF_LATENCY,
  parameter int NUM_CHECKS = c_DEF_NUM_CHECKS,
  parameter int CNT_W      = c_DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             i_start,
  input  logic             i_stim_valid,
  input  logic             i_stim_d,
  input  logic             i_dut_q,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_pass,
  output logic             o_mismatch,
  output logic [CNT_W-1:0] o_chk_cnt,
  output logic [CNT_W-1:0] o_err_cnt,
  output logic [CNT_W-1:0] o_first_err_idx
);

  localparam logic [CNT_W-1:0] c_NUM      = CNT_W'(NUM_CHECKS);
  localparam logic [CNT_W-1:0] c_ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] c_CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] c_ERR_NONE = c_FIRST_ERR_NONE[CNT_W-1:0];

  chk_state_t       r_state;
  chk_state_t       w_state_nxt;
  logic [CNT_W-1:0] r_push_cnt;
  logic [CNT_W-1:0] r_chk_cnt;
  logic [CNT_W-1:0] r_err_cnt;
  logic             r_mismatch;

  logic             w_busy;
  logic             w_push_tag;
  logic             w_tail_tag;
  logic             w_tail_data;
  logic             w_tail_tag_nxt;
  logic             w_cmp;
  logic             w_miss;
  logic [CNT_W-1:0] w_chk_inc;
  logic             w_last_cmp;

  assign w_busy     = (r_state == FILL) || (r_state == CHECK);
  // A start edge never captures stimulus nor performs a compare.
  assign w_push_tag = w_busy && !i_start && i_stim_valid && (r_push_cnt < c_NUM);
  assign w_cmp      = w_busy && !i_start && w_tail_tag;
  assign w_miss     = w_cmp && (i_dut_q != w_tail_data);
  assign w_chk_inc  = r_chk_cnt + c_ONE;
  assign w_last_cmp = w_cmp && (w_chk_inc == c_NUM);

  ff_chk_delay_line #(
    .LATENCY (LATENCY)
  ) u_delay_line (
    .clk            (clk),
    .rstn           (rstn),
    .i_clr          (i_start),
    .i_en           (w_busy),
    .i_tag          (w_push_tag),
    .i_data         (i_stim_d),
    .o_tail_tag     (w_tail_tag),
    .o_tail_data    (w_tail_data),
    .o_tail_tag_nxt (w_tail_tag_nxt)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (i_start) begin
      w_state_nxt = FILL;
    end else begin
      case (r_state)
        FILL: begin
          if (w_last_cmp) begin
            w_state_nxt = DONE;
          end else if (w_tail_tag_nxt) begin
            w_state_nxt = CHECK;
          end
        end
        CHECK: begin
          if (w_last_cmp) begin
            w_state_nxt = DONE;
          end
        end
        default: w_state_nxt = r_state;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_push_cnt <= '0;
      r_chk_cnt  <= '0;
      r_err_cnt  <= '0;
      r_mismatch <= 1'b0;
    end else begin
      r_mismatch <= w_miss;
      if (i_start) begin
        r_push_cnt <= '0;
        r_chk_cnt  <= '0;
        r_err_cnt  <= '0;
      end else begin
        if (w_push_tag) begin
          r_push_cnt <= r_push_cnt + c_ONE;
        end
        if (w_cmp) begin
          r_chk_cnt <= w_chk_inc;
        end
        if (w_miss && (r_err_cnt != c_CNT_MAX)) begin
          r_err_cnt <= r_err_cnt + c_ONE;
        end
      end
    end
  end

`ifdef FF_RESP_CHECKER_FIRST_ERR_EN
  logic [CNT_W-1:0] r_first_err_idx;

  // err_cnt never wraps to zero, so zero marks "no mismatch yet this run".
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_first_err_idx <= c_ERR_NONE;
    end else if (i_start) begin
      r_first_err_idx <= c_ERR_NONE;
    end else if (w_miss && (r_err_cnt == '0)) begin
      r_first_err_idx <= r_chk_cnt;
    end
  end

  assign o_first_err_idx = r_first_err_idx;
`else
  assign o_first_err_idx = c_ERR_NONE;
`endif

  assign o_busy     = w_busy;
  assign o_done     = (r_state == DONE);
  assign o_pass     = (r_state == DONE) && (r_err_cnt == '0);
  assign o_mismatch = r_mismatch;
  assign o_chk_cnt  = r_chk_cnt;
  assign o_err_cnt  = r_err_cnt;

endmodule
`default_nettype wire

// File: doc/ff_resp_checker.md
Name: ff_resp_checker

Overview:
- Synthesizable response checker for single-bit registered DUTs in the batch test benches.
- Receives the stimulus bit stream sent to the DUT and the DUT's registered output.
- Re-times each stimulus bit by a fixed latency, compares it against the DUT output, and counts checks and mismatches.
- Issues a pass/fail verdict after a fixed number of checks. Sits beside the stimulus FSM in syn_tb-style wrappers so pass/fail is visible in both simulation and on-board runs.

Parameters:
- LATENCY, 1: cycles from stim_d being sampled to the matching dut_q being sampled; legal range 1..16.
- NUM_CHECKS, 8: number of comparisons per run; legal range 1..(2**CNT_W)-1.
- CNT_W, 8: width of chk_cnt and err_cnt.

Ports:
- clk  in  1  single clock; all state updates on posedge.
- rstn  in  1  asynchronous, active-low reset.
- start  in  1  pulse; begins a run, or aborts and restarts one in progress.
- stim_valid  in  1  stim_d carries a sample this cycle.
- stim_d  in  1  stimulus bit driven to the DUT's d input.
- dut_q  in  1  DUT output.
- busy  out  1  high in FILL or CHECK.
- done  out  1  high in DONE.
- pass  out  1  done && err_cnt==0.
- mismatch  out  1  one-cycle registered pulse per failed compare.
- chk_cnt  out  CNT_W  compares performed in this run.
- err_cnt  out  CNT_W  mismatches, saturating.
- first_err_idx  out  CNT_W  see Optional Feature.

Behaviour:
- Reset (rstn low, asynchronous):
  - state = IDLE.
  - Delay line data and tags cleared.
  - push_cnt, chk_cnt, err_cnt = 0.
  - busy, done, pass, mismatch = 0.
  - first_err_idx = all ones.
- Reset released mid-run: the run is lost and the block waits in IDLE for start.
- States and transitions:
  - IDLE -> FILL on start.
  - FILL -> CHECK on the edge where the first tagged entry reaches the delay-line tail.
  - CHECK -> DONE on the edge where chk_cnt becomes NUM_CHECKS.
  - DONE holds until start, then returns to FILL.
- start in any state:
  - Clears counters, tags and first_err_idx, then enters FILL.
  - start in FILL/CHECK is an abort-restart.
- Delay line:
  - LATENCY-deep shift of {tag, data}, advancing every cycle while busy.
  - Head entry = {stim_valid && push_cnt<NUM_CHECKS, stim_d}; push_cnt increments on each tagged push.
  - stim_valid after NUM_CHECKS pushes, or outside FILL/CHECK, is ignored.
  - Gaps in stim_valid insert untagged bubbles.
- Compare:
  - On each edge where the tail tag is 1 (FILL or CHECK), compare dut_q against the tail data.
  - dut_q sampled at edge k+LATENCY is checked against stim_d sampled at edge k.
  - chk_cnt increments by 1.
  - On a mismatch, err_cnt increments, saturating at 2**CNT_W-1, and mismatch is high for the following cycle.
- Outputs are registered; done and pass are asserted the cycle after the final compare edge.
- Simultaneous events:
  - start on the final-compare edge: start wins; that compare is discarded.
  - stim_valid in the same cycle as start is not captured.

Optional Feature:
- Macro: FF_RESP_CHECKER_FIRST_ERR_EN.
- Defined: on the first mismatch of a run, first_err_idx captures the chk_cnt value before increment (0-based index). It holds until start or reset.
- Undefined: first_err_idx is tied to all ones, and no capture logic is built.

Decomposition:
- Package ff_chk_pkg holds:
  - the state enum typedef chk_state_t {IDLE, FILL, CHECK, DONE};
  - the default constants for LATENCY, NUM_CHECKS and CNT_W;
  - a localparam for the all-ones first_err_idx value.
- One sub-module, ff_chk_delay_line: parameterized LATENCY-deep {tag,data} shift register with synchronous clear (from start) and asynchronous rstn.
- The top level holds the FSM, counters and verdict.

Test Plan:
- Ideal DUT, LATENCY=1, NUM_CHECKS=8, stim 0,1,1,0,0,1,0,0 on consecutive cycles -> done 1 cycle after the 8th compare; chk_cnt=8, err_cnt=0, pass=1, mismatch never high.
- Same stim, DUT output inverted on the 4th sample -> err_cnt=1, pass=0, one mismatch pulse; first_err_idx=3 with the macro, all ones without.
- stim_valid pattern 1,0,1,1,0,1,1,1,1,1 (8 valid beats) -> exactly 8 compares, bubbles never compared, pass=1; beats beyond 8 ignored.
- LATENCY=3 with a 3-stage DUT pipe, 8 samples -> FILL spans 3 cycles, then 8 compares, pass=1; the same stim with LATENCY=2 produces err_cnt>0.
- start pulsed after 4 compares -> counters cleared, FILL re-entered, full 8 fresh compares, chk_cnt ends at 8.
- rstn asserted low after the 5th compare -> all outputs 0 immediately (asynchronous), first_err_idx all ones; after release, stays IDLE until start.
